// File: rtl/spin_control_input.sv
// Encoder/button input conditioner: sync, debounce, quadrature detent decode, speed/direction regs.
// Optional long-press speed reset enabled by defining SPIN_CTRL_LONG_PRESS_EN.
module spin_control_input #(
  parameter int unsigned DEBOUNCE_WIDTH   = 16,
  parameter logic [2:0]  SPEED_RESET      = 3'd4,
  parameter logic        DIR_RESET        = 1'b0,
  parameter int unsigned LONG_PRESS_WIDTH = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       btn_dir,
  output logic [2:0] speed,
  output logic       direction,
  output logic       step_pulse
);

  localparam logic [DEBOUNCE_WIDTH-1:0] DbMax = '1;

  // Bit order for all per-pin vectors: [0]=enc_a, [1]=enc_b, [2]=btn_dir.
  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] stable_q, stable_d;
  logic [DEBOUNCE_WIDTH-1:0] db_cnt_q [3];
  logic [DEBOUNCE_WIDTH-1:0] db_cnt_d [3];

  logic [1:0]        cur_ab;
  logic [1:0]        prev_q;
  logic signed [3:0] acc_q, acc_d, acc_next;
  logic              cw, ccw;
  logic              btn_prev_q, btn_rise;
  logic [2:0]        speed_q, speed_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;

  assign raw = {btn_dir, enc_b, enc_a};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign cur_ab = {stable_q[0], stable_q[1]};

  always_comb begin
    acc_next = acc_q;
    acc_d    = acc_q;
    cw       = 1'b0;
    ccw      = 1'b0;
    case ({prev_q, cur_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: acc_next = acc_q + 4'sd1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: acc_next = acc_q - 4'sd1;
      default: acc_next = acc_q;
    endcase
    if (cur_ab != prev_q) begin
      acc_d = acc_next;
      // Detent is judged including the step that lands on 00.
      if (cur_ab == 2'b00) begin
        cw    = (acc_next == 4'sd4);
        ccw   = (acc_next == -4'sd4);
        acc_d = '0;
      end
    end
  end

  assign btn_rise = stable_q[2] & ~btn_prev_q;

`ifdef SPIN_CTRL_LONG_PRESS_EN
  localparam logic [LONG_PRESS_WIDTH-1:0] LpMax  = '1;
  localparam logic [LONG_PRESS_WIDTH-1:0] LpFire = LpMax - 1'b1;
  logic [LONG_PRESS_WIDTH-1:0] lp_cnt_q, lp_cnt_d;
  logic                        lp_fire;

  always_comb begin
    lp_cnt_d = lp_cnt_q;
    lp_fire  = 1'b0;
    if (!stable_q[2]) begin
      lp_cnt_d = '0;
    end else if (lp_cnt_q != LpMax) begin
      lp_cnt_d = lp_cnt_q + 1'b1;
      lp_fire  = (lp_cnt_q == LpFire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lp_cnt_q <= '0;
    else        lp_cnt_q <= lp_cnt_d;
  end
`else
  logic lp_fire;
  assign lp_fire = 1'b0;
`endif

  always_comb begin
    speed_d = speed_q;
    if (cw && speed_q != 3'd7) begin
      speed_d = speed_q + 3'd1;
    end else if (ccw && speed_q != 3'd0) begin
      speed_d = speed_q - 3'd1;
    end
    if (lp_fire) speed_d = SPEED_RESET;
    dir_d  = dir_q ^ btn_rise;
    step_d = cw | ccw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      prev_q     <= '0;
      acc_q      <= '0;
      btn_prev_q <= 1'b0;
      speed_q    <= SPEED_RESET;
      dir_q      <= DIR_RESET;
      step_q     <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      prev_q     <= cur_ab;
      acc_q      <= acc_d;
      btn_prev_q <= stable_q[2];
      speed_q    <= speed_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
    end
  end

  assign speed      = speed_q;
  assign direction  = dir_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_spin_control_input.sv
// Directed plus randomized bench for spin_control_input with a detent-level reference model.
module tb_spin_control_input;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       btn_dir = 1'b0;
  logic [2:0] speed;
  logic       direction;
  logic       step_pulse;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int p0;
  int m_speed, m_dir, m_acc, m_prev, m_det;
  int lp_exp;

  spin_control_input #(
    .DEBOUNCE_WIDTH  (2),
    .LONG_PRESS_WIDTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .btn_dir   (btn_dir),
    .speed     (speed),
    .direction (direction),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step_pulse === 1'b1) pulses++;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_speed = 4;
    m_dir   = 0;
    m_acc   = 0;
    m_prev  = 0;
  endtask

  // Encoder position index 0..3 along the forward Gray cycle 00,01,11,10.
  task automatic phase(input int idx);
    int d;
    case (idx)
      0: {enc_a, enc_b} = 2'b00;
      1: {enc_a, enc_b} = 2'b01;
      2: {enc_a, enc_b} = 2'b11;
      default: {enc_a, enc_b} = 2'b10;
    endcase
    if (idx != m_prev) begin
      d = (idx - m_prev + 4) % 4;
      if (d == 1) m_acc++;
      else if (d == 3) m_acc--;
      if (m_acc > 7) m_acc -= 16;
      if (m_acc < -8) m_acc += 16;
      if (idx == 0) begin
        if (m_acc == 4) begin
          m_speed = (m_speed < 7) ? m_speed + 1 : 7;
          m_det++;
        end else if (m_acc == -4) begin
          m_speed = (m_speed > 0) ? m_speed - 1 : 0;
          m_det++;
        end
        m_acc = 0;
      end
      m_prev = idx;
    end
    cyc(10);
  endtask

  task automatic cw_detent();
    phase(1); phase(2); phase(3); phase(0);
  endtask

  task automatic ccw_detent();
    phase(3); phase(2); phase(1); phase(0);
  endtask

  initial begin
    m_det = 0;
    model_reset();
`ifdef SPIN_CTRL_LONG_PRESS_EN
    lp_exp = 4;
`else
    lp_exp = 2;
`endif
    cyc(3);
    check("rst_speed", speed, 4);
    check("rst_dir", direction, 0);
    check("rst_step", step_pulse, 0);
    reset = 1'b1;
    cyc(2);

    // Reach speed 6 with direction 1, then reset asynchronously between edges.
    cw_detent();
    cw_detent();
    check("pre_speed6", speed, m_speed);
    btn_dir = 1'b1; cyc(10);
    btn_dir = 1'b0; cyc(10);
    m_dir ^= 1;
    check("pre_dir1", direction, m_dir);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_speed", speed, 4);
    check("async_rst_dir", direction, 0);
    check("async_rst_step", step_pulse, 0);
    cyc(2);
    reset = 1'b1;
    model_reset();
    cyc(2);

    // Short glitch on A must not get through the debouncer.
    p0 = pulses;
    enc_a = 1'b1; cyc(3);
    enc_a = 1'b0; cyc(10);
    check("glitch_speed", speed, 4);
    check("glitch_pulses", pulses - p0, 0);

    // CW up to saturation.
    p0 = pulses;
    cw_detent();
    check("cw1_speed", speed, 5);
    check("cw1_pulses", pulses - p0, 1);
    for (int i = 0; i < 7; i++) begin
      cw_detent();
      check("cw_sat_speed", speed, m_speed);
    end
    check("cw_sat_final", speed, 7);
    check("cw_sat_pulses", pulses - p0, 8);

    // CCW down to zero and hold.
    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      ccw_detent();
      check("ccw_speed", speed, m_speed);
    end
    check("ccw_final", speed, 0);
    check("ccw_pulses", pulses - p0, 9);

    // Jitter then a full cycle, then an invalid double-bit jump.
    p0 = pulses;
    phase(1); phase(0);
    check("jitter_speed", speed, 0);
    phase(1); phase(2); phase(3); phase(0);
    check("jitter_cw_speed", speed, 1);
    phase(2); phase(0);
    check("invalid_speed", speed, 1);
    check("jitter_pulses", pulses - p0, 1);

    // Button hold: single toggle; long-press behaviour depends on build.
    cw_detent();
    check("lp_pre_speed", speed, 2);
    p0 = pulses;
    btn_dir = 1'b1;
    cyc(6);
    check("btn_dir_before", direction, m_dir);
    cyc(1);
    m_dir ^= 1;
    check("btn_dir_after", direction, m_dir);
    cyc(13);
    check("lp_speed_before", speed, 2);
    cyc(1);
    check("lp_speed_fire", speed, lp_exp);
    cyc(9);
    check("btn_hold_dir", direction, m_dir);
    check("btn_hold_speed", speed, lp_exp);
    btn_dir = 1'b0;
    cyc(15);
    check("btn_release_dir", direction, m_dir);
    check("btn_pulses", pulses - p0, 0);
    m_speed = lp_exp;

    // Random walks including invalid jumps.
    p0 = pulses;
    m_det = 0;
    for (int i = 0; i < 60; i++) begin
      int r, mv;
      r  = $urandom_range(0, 9);
      mv = (r < 5) ? 1 : ((r < 8) ? 3 : 2);
      phase((m_prev + mv) % 4);
      check("rand_speed", speed, m_speed);
    end
    phase(0);
    check("rand_speed_end", speed, m_speed);
    check("rand_pulses", pulses - p0, m_det);
    check("rand_dir", direction, m_dir);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
